// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  localparam int PS2_DATA_BITS = 8;

  function automatic int timeout_cycles(input int clk_hz, input int us);
    return (clk_hz / 1_000_000) * us;
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Two-flop synchroniser, debounce filter and falling-edge pulse for the PS/2 clock pin.
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          filt_reg;
  logic          filt_next;
  logic          fall_reg;
  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;

  // Flip only after FILTER_LEN consecutive samples disagree with the filtered level.
  always_comb begin
    filt_next = filt_reg;
    cnt_next  = '0;
    if (sync2_reg != filt_reg) begin
      if (cnt_reg == CW'(FILTER_LEN - 1)) begin
        filt_next = sync2_reg;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      filt_reg  <= 1'b1;
      cnt_reg   <= '0;
      fall_reg  <= 1'b0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      filt_reg  <= filt_next;
      cnt_reg   <= cnt_next;
      fall_reg  <= filt_reg & ~filt_next;
    end
  end

  assign fall = fall_reg;

endmodule

// File: rtl/ps2_rx.sv
// PS/2 keyboard frame receiver: start, 8 data bits LSB-first, odd parity, stop,
// with parity/frame error pulses and an inactivity timeout.
import ps2_pkg::*;

module ps2_rx #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_US  = 200
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_data,
  output logic       o_data_ready,
  output logic       o_parity_err,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int TIMEOUT_CYCLES = timeout_cycles(CLK_FREQ_HZ, TIMEOUT_US);
  localparam int TW             = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BW             = $clog2(PS2_DATA_BITS);

  logic                     clk_fall;
  logic                     data_sync1_reg;
  logic                     data_sync2_reg;

  ps2_state_t               state_reg, state_next;
  logic [BW-1:0]            bit_cnt_reg, bit_cnt_next;
  logic [PS2_DATA_BITS-1:0] shreg_reg, shreg_next;
  logic                     par_reg, par_next;
  logic [TW-1:0]            tmo_reg, tmo_next;
  logic [7:0]               data_reg, data_next;
  logic                     ready_reg, ready_next;
  logic                     perr_reg, perr_next;
  logic                     ferr_reg, ferr_next;

  ps2_clk_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_clk_filter (
    .clk  (i_clk),
    .rst_n(i_rst_n),
    .raw  (i_ps2_clk),
    .fall (clk_fall)
  );

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    shreg_next   = shreg_reg;
    par_next     = par_reg;
    tmo_next     = '0;
    data_next    = data_reg;
    ready_next   = 1'b0;
    perr_next    = 1'b0;
    ferr_next    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (clk_fall && !data_sync2_reg) begin
          state_next   = DATA;
          bit_cnt_next = '0;
        end
      end
      DATA: begin
        if (clk_fall) begin
          shreg_next   = {data_sync2_reg, shreg_reg[PS2_DATA_BITS-1:1]};
          bit_cnt_next = bit_cnt_reg + 1'b1;
          if (bit_cnt_reg == BW'(PS2_DATA_BITS - 1)) begin
            state_next = PARITY;
          end
        end
      end
      PARITY: begin
        if (clk_fall) begin
          par_next   = data_sync2_reg;
          state_next = STOP;
        end
      end
      STOP: begin
        if (clk_fall) begin
          state_next = IDLE;
          // A missing stop bit outranks a parity failure.
          if (!data_sync2_reg) begin
            ferr_next = 1'b1;
          end else if ((^shreg_reg ^ par_reg) == 1'b0) begin
            perr_next = 1'b1;
          end else begin
            data_next  = shreg_reg;
            ready_next = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // A fall in the timeout cycle wins: the counter only advances when no bit arrives.
    if (state_reg != IDLE && !clk_fall) begin
      if (tmo_reg == TW'(TIMEOUT_CYCLES)) begin
        state_next = IDLE;
        ferr_next  = 1'b1;
      end else begin
        tmo_next = tmo_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_sync1_reg <= 1'b1;
      data_sync2_reg <= 1'b1;
      state_reg      <= IDLE;
      bit_cnt_reg    <= '0;
      shreg_reg      <= '0;
      par_reg        <= 1'b0;
      tmo_reg        <= '0;
      data_reg       <= '0;
      ready_reg      <= 1'b0;
      perr_reg       <= 1'b0;
      ferr_reg       <= 1'b0;
    end else begin
      data_sync1_reg <= i_ps2_data;
      data_sync2_reg <= data_sync1_reg;
      state_reg      <= state_next;
      bit_cnt_reg    <= bit_cnt_next;
      shreg_reg      <= shreg_next;
      par_reg        <= par_next;
      tmo_reg        <= tmo_next;
      data_reg       <= data_next;
      ready_reg      <= ready_next;
      perr_reg       <= perr_next;
      ferr_reg       <= ferr_next;
    end
  end

  assign o_data       = data_reg;
  assign o_data_ready = ready_reg;
  assign o_parity_err = perr_reg;
  assign o_frame_err  = ferr_reg;
  assign o_busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_ps2_rx.sv
// Directed and randomized PS/2 frame stimulus checked against a frame-level outcome model.
module tb_ps2_rx;

  localparam int CLK_HZ = 2_000_000;
  localparam int FLEN   = 8;
  localparam int TO_US  = 200;
  localparam int TO_CYC = CLK_HZ / 1_000_000 * TO_US;
  localparam int QTR    = 40;   // 12.5 kHz PS/2 bit = 160 system cycles
  localparam int HALF   = 80;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] data;
  logic       ready, perr, ferr, busy;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         n_ready = 0, n_perr = 0, n_ferr = 0, n_overlap = 0;
  int         ferr_cyc = 0;
  int         last_fall_cyc = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_data = 8'h00;

  always #5 clk = ~clk;

  ps2_rx #(
    .CLK_FREQ_HZ(CLK_HZ),
    .FILTER_LEN (FLEN),
    .TIMEOUT_US (TO_US)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_ps2_clk   (ps2_clk),
    .i_ps2_data  (ps2_data),
    .o_data      (data),
    .o_data_ready(ready),
    .o_parity_err(perr),
    .o_frame_err (ferr),
    .o_busy      (busy)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ready) begin
      n_ready++;
      rx_q.push_back(data);
    end
    if (perr) n_perr++;
    if (ferr) begin
      n_ferr++;
      ferr_cyc = cyc;
    end
    if ((32'(ready) + 32'(perr) + 32'(ferr)) > 1) n_overlap++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [10:0] frame(input logic [7:0] d, input logic p, input logic st);
    return {st, p, d, 1'b0};
  endfunction

  // Odd parity: data plus parity bit carry an odd number of ones.
  function automatic logic good_par(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += 32'(d[i]);
    return (ones % 2 == 0) ? 1'b1 : 1'b0;
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n, input bit glitch);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      if (glitch) begin
        wait_cyc(10); ps2_clk = 1'b0; wait_cyc(3); ps2_clk = 1'b1; wait_cyc(QTR - 13);
      end else begin
        wait_cyc(QTR);
      end
      ps2_clk = 1'b0;
      last_fall_cyc = cyc;
      if (glitch) begin
        wait_cyc(30); ps2_clk = 1'b1; wait_cyc(3); ps2_clk = 1'b0; wait_cyc(HALF - 33);
      end else begin
        wait_cyc(HALF);
      end
      ps2_clk = 1'b1;
      wait_cyc(QTR);
    end
  endtask

  task automatic run_frame(input string tag, input logic [7:0] d, input logic p,
                           input logic st, input bit glitch);
    int   r0, p0, f0;
    logic exp_ferr, exp_perr, exp_ok;
    logic [31:0] got;
    r0 = n_ready; p0 = n_perr; f0 = n_ferr;
    rx_q.delete();
    exp_ferr = !st;
    exp_perr = st && (p != good_par(d));
    exp_ok   = !exp_ferr && !exp_perr;
    send_bits(frame(d, p, st), 11, glitch);
    ps2_data = 1'b1;
    wait_cyc(20);
    check({tag, ".ready_cnt"}, 32'(n_ready - r0), 32'(exp_ok));
    check({tag, ".perr_cnt"},  32'(n_perr - p0),  32'(exp_perr));
    check({tag, ".ferr_cnt"},  32'(n_ferr - f0),  32'(exp_ferr));
    if (exp_ok) begin
      exp_data = d;
      got = (rx_q.size() > 0) ? 32'(rx_q.pop_front()) : 32'hFFFF_FFFF;
      check({tag, ".rx_byte"}, got, 32'(d));
    end
    check({tag, ".o_data"}, 32'(data), 32'(exp_data));
    check({tag, ".busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int          r0, f0, lat, lat_exp;
    logic [7:0]  rd;
    logic        rp, rs;
    logic [31:0] got;

    // Reset state
    wait_cyc(3);
    check("reset.o_data", 32'(data), 32'h00);
    check("reset.flags", {29'd0, ready, perr, ferr}, 32'd0);
    check("reset.busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    wait_cyc(20);

    run_frame("f1c", 8'h1C, 1'b0, 1'b1, 1'b0);

    // Back-to-back frames with no extra gap
    r0 = n_ready;
    rx_q.delete();
    send_bits(frame(8'hF0, 1'b1, 1'b1), 11, 1'b0);
    send_bits(frame(8'h1C, 1'b0, 1'b1), 11, 1'b0);
    wait_cyc(20);
    check("b2b.ready_cnt", 32'(n_ready - r0), 32'd2);
    got = (rx_q.size() > 0) ? 32'(rx_q.pop_front()) : 32'hFFFF_FFFF;
    check("b2b.first", got, 32'hF0);
    got = (rx_q.size() > 0) ? 32'(rx_q.pop_front()) : 32'hFFFF_FFFF;
    check("b2b.second", got, 32'h1C);
    exp_data = 8'h1C;

    // Parity error must leave o_data alone; start from a clean post-reset value
    rst_n = 1'b0; wait_cyc(2); rst_n = 1'b1; exp_data = 8'h00; wait_cyc(10);
    run_frame("bad_par", 8'h1C, 1'b1, 1'b1, 1'b0);
    run_frame("bad_stop_par", 8'h1C, 1'b1, 1'b0, 1'b0);

    // Timeout after start + 3 data bits
    f0 = n_ferr;
    send_bits(frame(8'h05, 1'b1, 1'b1), 4, 1'b0);
    wait_cyc(2 * TO_CYC + 100 - QTR);
    check("timeout.ferr_cnt", 32'(n_ferr - f0), 32'd1);
    lat     = ferr_cyc - last_fall_cyc;
    lat_exp = TO_CYC + 2 + FLEN + 2;
    if (lat >= lat_exp - 2 && lat <= lat_exp + 2) lat = lat_exp;
    check("timeout.latency", 32'(lat), 32'(lat_exp));
    check("timeout.busy", 32'(busy), 32'd0);
    ps2_data = 1'b1;
    wait_cyc(20);
    run_frame("f5a", 8'h5A, 1'b1, 1'b1, 1'b0);

    // Glitches on the clock pin must be filtered out
    run_frame("glitch29", 8'h29, 1'b0, 1'b1, 1'b1);

    // Reset in the middle of a frame
    f0 = n_ferr;
    send_bits(frame(8'h29, 1'b0, 1'b1), 4, 1'b0);
    check("midrst.busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst.o_data", 32'(data), 32'h00);
    check("midrst.flags", {29'd0, ready, perr, ferr}, 32'd0);
    check("midrst.busy", 32'(busy), 32'd0);
    wait_cyc(2);
    rst_n = 1'b1;
    ps2_data = 1'b1;
    exp_data = 8'h00;
    wait_cyc(2 * TO_CYC);
    check("midrst.no_ferr", 32'(n_ferr - f0), 32'd0);
    run_frame("after_rst29", 8'h29, 1'b0, 1'b1, 1'b0);

    // Randomized frames
    for (int i = 0; i < 16; i++) begin
      rd = 8'($urandom_range(0, 255));
      rp = good_par(rd);
      if ($urandom_range(0, 3) == 0) rp = ~rp;
      rs = ($urandom_range(0, 5) != 0);
      run_frame($sformatf("rand%0d_%02h", i, rd), rd, rp, rs, ($urandom_range(0, 1) == 1));
    end

    check("no_overlap", 32'(n_overlap), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_rx.md
Name: ps2_rx

Overview:
Receives PS/2 keyboard frames from the Nexys A7 USB-HID bridge pins (PS2_CLK, PS2_DATA) and emits one 8-bit scan-code byte per valid frame.
o_data and the one-cycle o_data_ready pulse feed directly into the keyboard Wishbone peripheral's data/ready inputs.
The block provides:
- input synchronisation and glitch filtering of the PS/2 clock;
- frame decoding (start, 8 data LSB-first, odd parity, stop);
- error reporting and an inactivity timeout.

Parameters:
CLK_FREQ_HZ, 100_000_000, system clock frequency in Hz.
FILTER_LEN, 8, consecutive equal samples required before the filtered PS/2 clock changes level (range 2..32).
TIMEOUT_US, 200, maximum gap between PS/2 clock falling edges inside a frame, in microseconds.

Ports:
i_clk  in  1  system clock; all logic on its rising edge.
i_rst_n  in  1  asynchronous active-low reset.
i_ps2_clk  in  1  raw PS/2 clock pin, asynchronous, idles high.
i_ps2_data  in  1  raw PS/2 data pin, asynchronous, idles high.
o_data  out  8  last correctly received byte.
o_data_ready  out  1  one-cycle pulse; o_data is valid and new.
o_parity_err  out  1  one-cycle pulse; frame had a bad parity bit and was discarded.
o_frame_err  out  1  one-cycle pulse; bad stop bit or timeout, frame discarded.
o_busy  out  1  high while a frame is in progress (FSM not IDLE).

Behaviour:
- Reset is asynchronous and active-low. While i_rst_n=0:
  - o_data=0x00; o_data_ready, o_parity_err, o_frame_err and o_busy are 0;
  - FSM is IDLE, bit counter and timeout counter are 0;
  - synchronisers and the filtered clock are 1.
- Reset deasserted mid-frame: receiver starts fresh in IDLE; the partial frame is lost and no error is flagged.
- Sync: i_ps2_clk and i_ps2_data each pass through 2 flops.
- Clock filter:
  - a counter tracks consecutive synced samples differing from the current filtered level;
  - the filtered level flips when the count reaches FILTER_LEN; any matching sample clears the count;
  - pulses shorter than FILTER_LEN cycles are ignored.
- Falling edge: fall = filt_prev & ~filt. The synced data bit is sampled in the same cycle.
- FSM states:
  - IDLE: on fall with data=0 -> DATA, bit_cnt=0. On fall with data=1 (no start bit): stay in IDLE, no flag.
  - DATA: on fall, shreg <= {d, shreg[7:1]}, bit_cnt++. When the 8th bit is taken (bit_cnt==7) -> PARITY.
  - PARITY: on fall, latch p -> STOP.
  - STOP: on fall, evaluate the frame and return to IDLE:
    - stop bit = 0 -> o_frame_err pulse (takes priority over a parity error);
    - else (^shreg ^ p) = 0 -> o_parity_err pulse;
    - else o_data <= shreg and o_data_ready pulse.
- Latency: the output or flag pulse is registered and asserts 1 cycle after the cycle in which the stop-bit fall is detected.
- Total latency from the raw pin edge is 2 + FILTER_LEN + 2 cycles (±1 for sample phase).
- o_data is unchanged on any error.
- Timeout:
  - TIMEOUT_CYCLES = CLK_FREQ_HZ/1_000_000*TIMEOUT_US; the counter width is $clog2(TIMEOUT_CYCLES+1);
  - the counter clears on every fall and while in IDLE, and counts otherwise;
  - on reaching TIMEOUT_CYCLES in any non-IDLE state: -> IDLE and one o_frame_err pulse;
  - a fall in the same cycle as the timeout takes priority, i.e. the bit is accepted.
- Pulses never overlap; at most one of o_data_ready, o_parity_err and o_frame_err is high in any cycle.
- Back-to-back frames need no idle gap beyond the PS/2 stop-bit period.
- Receive-only: the block never drives the PS/2 lines.

Decomposition:
- Package ps2_pkg:
  - state enum ps2_state_t {IDLE, DATA, PARITY, STOP};
  - constant PS2_DATA_BITS=8;
  - function timeout_cycles(clk_hz, us).
- Sub-module ps2_clk_filter: 2-flop synchroniser plus FILTER_LEN debounce and registered falling-edge pulse; one instance for the clock.
- The data pin uses only the 2-flop synchroniser, kept inline.

Test Plan:
- Send 0x1C (bits 0,0,1,1,1,0,0,0; parity 0; stop 1) at 12.5 kHz -> single o_data_ready pulse, o_data=0x1C, no error pulses, o_busy low afterwards.
- Send 0xF0 then 0x1C back-to-back (0xF0 parity=1) -> two o_data_ready pulses; o_data=0xF0, then 0x1C.
- Send 0x1C with parity=1 -> one o_parity_err pulse, no o_data_ready, o_data holds its previous value (0x00 after reset).
- Send 0x1C with stop=0 and also bad parity -> exactly one o_frame_err pulse, no o_parity_err, no o_data_ready.
- Timeout: start plus 3 data bits, then hold the clock high for 250 us -> o_frame_err pulse at 200 us (±1 cycle), o_busy=0; then a full 0x5A frame (parity 1) -> o_data=0x5A.
- Glitch and reset:
  - 3-cycle low pulses injected on i_ps2_clk (FILTER_LEN=8) during the 0x29 frame (parity 0) -> o_data=0x29, not corrupted;
  - i_rst_n low for 2 cycles after 4 bits of a frame -> all outputs 0 immediately, then a subsequent 0x29 is received correctly.
